pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 8 +
 rtl/pipe_ctrl_hazard_detect.sv | 10 +
 rtl/pipe_ctrl.sv | 92 +++++++++
 tb/tb_pipe_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and default sizes for the pipeline controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, IMISS = 2'd1, DMISS = 2'd2} state_e;
  localparam int CNT_W_DEF = 16;
  localparam int MISS_LIMIT_DEF = 255;
  localparam int TIMER_W = 8;
  localparam int REG_W = 5;
endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: flags a load in EX whose destination feeds the instruction in ID
module hazard_detect import pipe_ctrl_pkg::*; (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  output logic             load_use
);
  assign load_use = ex_memread && ex_rt != '0 && (ex_rt == id_rs || ex_rt == id_rt);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller with miss FSM, stall counter and sticky miss timeout
module pipe_ctrl import pipe_ctrl_pkg::*; #(
  parameter int MISS_LIMIT = MISS_LIMIT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_hit,
  input  logic             dmem_req,
  input  logic             dmem_hit,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic             miss_err
);
  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(MISS_LIMIT);
  state_e state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [TIMER_W-1:0] miss_timer_q, miss_timer_d;
  logic miss_err_q, miss_err_d;
  logic load_use, dstall, timeout;
  hazard_detect u_hd (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .load_use   (load_use)
  );
  assign dstall = dmem_req && !dmem_hit;
  // enables follow the current inputs; reset forces a full flush with everything frozen
  always_comb begin
    pc_we = 1'b1;
    ifid_we = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exmem_we = 1'b1;
    if (rst) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exmem_we = 1'b0;
    end else if (dstall) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      exmem_we = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_we = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use || !imem_hit) begin
      pc_we = 1'b0;
      ifid_we = 1'b0;
      idex_flush = 1'b1;
    end
  end
  always_comb begin
    state_d = RUN;
    if (state_q == RUN) state_d = dstall ? DMISS : (!imem_hit && !ex_branch_taken) ? IMISS : RUN;
    else if (state_q == IMISS) state_d = (imem_hit || ex_branch_taken) ? RUN : IMISS;
    else if (state_q == DMISS) state_d = dmem_hit ? RUN : DMISS;
    timeout = (state_q == IMISS || state_q == DMISS) && miss_timer_q == LIMIT;
    miss_timer_d = state_d == RUN ? '0 : state_d == state_q ? miss_timer_q + TIMER_W'(1) : miss_timer_q;
    stall_count_d = (!pc_we && stall_count_q != '1) ? stall_count_q + CNT_W'(1) : stall_count_q;
    miss_err_d = miss_err_q || timeout;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      stall_count_q <= '0;
      miss_timer_q <= '0;
      miss_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_count_q <= stall_count_d;
      miss_timer_q <= miss_timer_d;
      miss_err_q <= miss_err_d;
    end
  end
  assign state = state_q;
  assign stall_count = stall_count_q;
  assign miss_err = miss_err_q || timeout;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random stimulus against a cycle-level reference of the controller
module tb_pipe_ctrl;
  localparam int CW = 4;
  localparam int LIM = 255;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_hit = 1'b1, dmem_req = 1'b0, dmem_hit = 1'b1, ex_memread = 1'b0, ex_branch_taken = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, miss_err;
  logic [1:0] state;
  logic [CW-1:0] stall_count;
  int vec = 0, errs = 0;
  int m_state = 0, m_cnt = 0, m_timer = 0;
  bit m_err = 0;
  pipe_ctrl #(.MISS_LIMIT(LIM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .imem_hit(imem_hit), .dmem_req(dmem_req), .dmem_hit(dmem_hit),
    .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_we(exmem_we), .state(state), .stall_count(stall_count),
    .miss_err(miss_err)
  );
  always #5 clk = ~clk;
  // {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we} from the priority rules
  function automatic logic [4:0] exp_en();
    if (rst) return 5'b00110;
    if (dmem_req && !dmem_hit) return 5'b00000;
    if (ex_branch_taken) return 5'b10111;
    if ((ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt)) || !imem_hit) return 5'b00011;
    return 5'b11001;
  endfunction
  function automatic bit exp_err();
    return m_err || (m_state != 0 && m_timer == LIM);
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0;
      m_cnt = 0;
      m_timer = 0;
      m_err = 0;
    end else begin : upd
      int nxt;
      logic [4:0] e;
      e = exp_en();
      if (m_state == 0) nxt = (dmem_req && !dmem_hit) ? 2 : (!imem_hit && !ex_branch_taken) ? 1 : 0;
      else if (m_state == 1) nxt = (imem_hit || ex_branch_taken) ? 0 : 1;
      else nxt = dmem_hit ? 0 : 2;
      if (!e[4] && m_cnt < 2**CW - 1) m_cnt++;
      m_err = exp_err();
      m_timer = nxt == 0 ? 0 : nxt == m_state ? (m_timer + 1) % 256 : m_timer;
      m_state = nxt;
    end
  end
  always @(negedge clk) begin : cmp
    logic [4:0] e;
    bit ok;
    e = exp_en();
    ok = {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we} == e && state == 2'(m_state) &&
         stall_count == CW'(m_cnt) && miss_err == exp_err();
    vec++;
    if (!ok) begin
      errs++;
      $display("FAIL cycle t=%0t got en=%b st=%0d cnt=%0d err=%b want en=%b st=%0d cnt=%0d err=%b",
               $time, {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we}, state, stall_count, miss_err,
               e, m_state, m_cnt, exp_err());
    end
  end
  task automatic chk(string nm, int act, int exp);
    vec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask
  task automatic drive(bit ih, bit dr, bit dh, bit br, bit mr, logic [4:0] rs, logic [4:0] rt, logic [4:0] xrt);
    imem_hit = ih; dmem_req = dr; dmem_hit = dh; ex_branch_taken = br;
    ex_memread = mr; id_rs = rs; id_rt = rt; ex_rt = xrt;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic normal;
    drive(1, 0, 1, 0, 0, 0, 0, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    mid;
    chk("rst_pc_we", pc_we, 0);
    chk("rst_flush", {ifid_flush, idex_flush}, 3);
    chk("rst_exmem_we", exmem_we, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 0, 1, 0, 1, 5, 0, 5);
    mid;
    chk("lu_pc_we", pc_we, 0);
    chk("lu_ifid_we", ifid_we, 0);
    chk("lu_idex_flush", idex_flush, 1);
    chk("lu_cnt_before", stall_count, 0);
    tick; normal; mid;
    chk("lu_cnt_after", stall_count, 1);
    tick; drive(1, 0, 1, 0, 1, 0, 0, 0); mid;
    chk("r0_pc_we", pc_we, 1);
    chk("r0_ifid_we", ifid_we, 1);
    for (int i = 0; i < 3; i++) begin
      tick; drive(0, 0, 1, 0, 0, 0, 0, 0); mid;
      chk("imiss_state", state, i == 0 ? 0 : 1);
    end
    tick; normal; mid;
    chk("imiss_last_state", state, 1);
    tick; mid;
    chk("imiss_done_state", state, 0);
    chk("imiss_cnt", stall_count, 4);
    tick; drive(0, 0, 1, 0, 0, 0, 0, 0);
    tick; drive(0, 0, 1, 1, 0, 0, 0, 0); mid;
    chk("br_state", state, 1);
    chk("br_ifid_flush", ifid_flush, 1);
    chk("br_pc_we", pc_we, 1);
    tick; normal; mid;
    chk("br_abort_state", state, 0);
    for (int i = 0; i < 3; i++) begin
      tick; drive(1, 1, 0, 1, 0, 0, 0, 0); mid;
      chk("ds_en", {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we}, 0);
    end
    tick; drive(1, 1, 1, 0, 0, 0, 0, 0); mid;
    chk("ds_release_pc_we", pc_we, 1);
    chk("ds_cnt", stall_count, 8);
    for (int i = 0; i < 10; i++) begin
      tick; drive(0, 0, 1, 0, 0, 0, 0, 0);
    end
    tick; normal; tick; normal; mid;
    chk("cnt_saturate", stall_count, 15);
    for (int j = 1; j <= 300; j++) begin
      tick; drive(1, 1, 0, 0, 0, 0, 0, 0); mid;
      if (j == 256) chk("merr_early", miss_err, 0);
      if (j == 257) chk("merr_set", miss_err, 1);
    end
    chk("merr_hold", miss_err, 1);
    tick; drive(1, 1, 1, 0, 0, 0, 0, 0);
    tick; normal; tick; mid;
    chk("merr_sticky", miss_err, 1);
    chk("merr_no_fsm_effect", state, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("async_merr", miss_err, 0);
    chk("async_cnt", stall_count, 0);
    tick; rst = 1'b0; drive(0, 0, 1, 0, 0, 0, 0, 0);
    tick; tick; mid;
    chk("pre_rst_imiss", state, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("rst_mid_miss", state, 0);
    tick; rst = 1'b0; normal;
    tick; mid;
    chk("after_rst_run", state, 0);
    for (int i = 0; i < 3000; i++) begin
      tick;
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) < 3, $urandom_range(0, 9) < 3, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        tick;
        rst = 1'b0;
      end
    end
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
